// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit datapath ALU and its built-in self-test:
// op encodings, LFSR/MISR polynomials and the BIST state type.
package alu_pkg;

   localparam logic [2:0] OP_ROL = 3'd0;
   localparam logic [2:0] OP_SLL = 3'd1;
   localparam logic [2:0] OP_ROR = 3'd2;
   localparam logic [2:0] OP_SRA = 3'd3;
   localparam logic [2:0] OP_ADD = 3'd4;
   localparam logic [2:0] OP_OR  = 3'd5;
   localparam logic [2:0] OP_XOR = 3'd6;
   localparam logic [2:0] OP_AND = 3'd7;

   localparam logic [15:0] LFSR_MASK = 16'hB400;
   localparam logic [15:0] MISR_POLY = 16'h100B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } bist_state_t;

   // Galois right-shift step
   function automatic logic [15:0] lfsr_step(input logic [15:0] x);
      return {1'b0, x[15:1]} ^ (x[0] ? LFSR_MASK : 16'h0000);
   endfunction

   function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] r);
      return ({s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000)) ^ r;
   endfunction

endpackage

// File: rtl/alu_bist_lfsr16.sv
// 16-bit Galois LFSR; q_next exposes the value the register takes at the
// next edge so the caller can register it alongside without a cycle of lag.
module lfsr16
   import alu_pkg::*;
#(
   parameter logic [15:0] SEED = 16'h0001
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        step,
   output logic [15:0] q_next
);

   logic [15:0] q;

   always_comb begin
      q_next = q;
      if (load)
         q_next = SEED;
      else if (step)
         q_next = lfsr_step(q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q <= SEED;
      else
         q <= q_next;
   end

endmodule

// File: rtl/alu_bist.sv
// ALU built-in self-test: streams LFSR operand vectors into the ALU, one per
// cycle, and folds the responses into a MISR compared against a golden value.
module alu_bist
   import alu_pkg::*;
#(
   parameter int unsigned NUM_VEC = 256,
   parameter logic [15:0] SEED_A  = 16'hACE1,
   parameter logic [15:0] SEED_B  = 16'h1234,
   parameter logic [15:0] EXP_SIG = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] sig,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic        alu_cin,
   output logic [2:0]  alu_op,
   output logic        alu_invA,
   output logic        alu_invB,
   output logic        alu_sign,
   input  logic [15:0] alu_out,
   input  logic        alu_ofl,
   input  logic        alu_zero
);

   bist_state_t state;
   logic [15:0] v;
   logic [15:0] v_inc;
   logic [15:0] lfsr_a_next;
   logic [15:0] lfsr_b_next;
   logic [15:0] resp;
   logic [15:0] sig_next;
   logic        last;
   logic        launch;
   logic        step;

   assign v_inc  = v + 16'd1;
   assign last   = (v == 16'(NUM_VEC - 1));
   assign launch = start && (state != RUN);
   assign step   = (state == RUN) && !last;

   // overflow is only meaningful for ADD; other ops leave it undefined
   assign resp     = alu_out ^ {14'b0, alu_ofl & (alu_op == OP_ADD), alu_zero};
   assign sig_next = misr_step(sig, resp);

   lfsr16 #(.SEED(SEED_A)) u_lfsr_a (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (launch),
      .step   (step),
      .q_next (lfsr_a_next)
   );

   lfsr16 #(.SEED(SEED_B)) u_lfsr_b (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (launch),
      .step   (step),
      .q_next (lfsr_b_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         sig      <= 16'h0000;
         v        <= 16'h0000;
         alu_a    <= 16'h0000;
         alu_b    <= 16'h0000;
         {alu_sign, alu_invB, alu_invA, alu_cin, alu_op} <= 7'd0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state <= RUN;
                  busy  <= 1'b1;
                  done  <= 1'b0;
                  pass  <= 1'b0;
                  sig   <= 16'h0000;
                  v     <= 16'h0000;
                  alu_a <= lfsr_a_next;
                  alu_b <= lfsr_b_next;
                  {alu_sign, alu_invB, alu_invA, alu_cin, alu_op} <= 7'd0;
               end
            end
            RUN: begin
               sig <= sig_next;
               if (last) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (sig_next == EXP_SIG);
                  alu_a <= 16'h0000;
                  alu_b <= 16'h0000;
                  {alu_sign, alu_invB, alu_invA, alu_cin, alu_op} <= 7'd0;
               end else begin
                  v     <= v_inc;
                  alu_a <= lfsr_a_next;
                  alu_b <= lfsr_b_next;
                  // control fields are the low bits of the vector index
                  {alu_sign, alu_invB, alu_invA, alu_cin, alu_op} <= v_inc[6:0];
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist: a behavioural ALU closes the loop, and a
// plain-arithmetic model predicts operands and the final signature.
module tb_alu_bist;

   // ---------------- behavioural reference ----------------
   function automatic logic [17:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                         input logic [2:0] op, input logic cin,
                                         input logic inva, input logic invb, input logic sgn);
      logic [15:0] x, y, o;
      logic [31:0] w;
      logic [16:0] sum;
      logic [3:0]  s;
      logic        ofl;
      x = inva ? ~a : a;
      y = invb ? ~b : b;
      s = y[3:0];
      o = 16'h0;
      ofl = 1'b0;
      w = 32'h0;
      sum = 17'h0;
      case (op)
         3'd0: begin w = {x, x} << s; o = w[31:16]; end
         3'd1: o = x << s;
         3'd2: begin w = {x, x} >> s; o = w[15:0]; end
         3'd3: begin w = {{16{x[15]}}, x} >> s; o = w[15:0]; end
         3'd4: begin
            sum = {1'b0, x} + {1'b0, y} + {16'h0, cin};
            o   = sum[15:0];
            ofl = sgn ? ((x[15] == y[15]) && (o[15] != x[15])) : sum[16];
         end
         3'd5: o = x | y;
         3'd6: o = x ^ y;
         default: o = x & y;
      endcase
      return {ofl, (o == 16'h0), o};
   endfunction

   function automatic logic [15:0] gal(input logic [15:0] x);
      return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
   endfunction

   // operands {a,b} of vector n
   function automatic logic [31:0] model_ab(input int n);
      logic [15:0] a, b;
      a = 16'hACE1;
      b = 16'h1234;
      for (int i = 0; i < n; i++) begin
         a = gal(a);
         b = gal(b);
      end
      return {a, b};
   endfunction

   function automatic logic [15:0] model_sig(input int n);
      logic [15:0] a, b, s, r, vv;
      logic [17:0] res;
      a = 16'hACE1;
      b = 16'h1234;
      s = 16'h0000;
      for (int i = 0; i < n; i++) begin
         vv  = 16'(i);
         res = alu_f(a, b, vv[2:0], vv[3], vv[4], vv[5], vv[6]);
         r   = res[15:0] ^ {14'b0, res[17] & (vv[2:0] == 3'd4), res[16]};
         s   = ((s << 1) ^ (s[15] ? 16'h100B : 16'h0000)) ^ r;
         a   = gal(a);
         b   = gal(b);
      end
      return s;
   endfunction

   localparam logic [15:0] GOLD = model_sig(256);

   // ---------------- DUTs ----------------
   logic clk = 1'b0;
   logic rst_n;
   logic fault;
   always #5 clk = ~clk;

   logic        start1, busy1, done1, pass1, cin1, inva1, invb1, sign1, ofl1, zero1;
   logic [15:0] sig1, a1, b1, out1;
   logic [2:0]  op1;
   logic        start2, busy2, done2, pass2, cin2, inva2, invb2, sign2, ofl2, zero2;
   logic [15:0] sig2, a2, b2, out2;
   logic [2:0]  op2;
   logic [17:0] res2;

   always_comb {ofl1, zero1, out1} = alu_f(a1, b1, op1, cin1, inva1, invb1, sign1);
   always_comb begin
      res2 = alu_f(a2, b2, op2, cin2, inva2, invb2, sign2);
      out2 = res2[15:0] & {15'h7FFF, ~fault};
      zero2 = res2[16];
      ofl2  = res2[17];
   end

   alu_bist #(.NUM_VEC(1), .EXP_SIG(16'hCE1A)) u_one (
      .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
      .sig(sig1), .alu_a(a1), .alu_b(b1), .alu_cin(cin1), .alu_op(op1),
      .alu_invA(inva1), .alu_invB(invb1), .alu_sign(sign1),
      .alu_out(out1), .alu_ofl(ofl1), .alu_zero(zero1));

   alu_bist #(.NUM_VEC(256), .EXP_SIG(GOLD)) u_full (
      .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
      .sig(sig2), .alu_a(a2), .alu_b(b2), .alu_cin(cin2), .alu_op(op2),
      .alu_invA(inva2), .alu_invB(invb2), .alu_sign(sign2),
      .alu_out(out2), .alu_ofl(ofl2), .alu_zero(zero2));

   // ---------------- checking ----------------
   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   logic [15:0] obs_a [300];
   logic [15:0] obs_b [300];
   logic [6:0]  obs_ctl [300];

   typedef struct {
      int          v;
      logic [15:0] a;
      logic [15:0] b;
      logic [6:0]  ctl;
   } vec_t;
   vec_t tbl [9];

   // Runs the 256-vector DUT; pulses start during RUN at cycles p1 and p2.
   task automatic run_full(input int p1, input int p2, output logic [15:0] s,
                           output int nbusy, output logic d, output logic p,
                           output logic done_at_start);
      int k;
      @(posedge clk); #1 start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      done_at_start = done2;
      k = 0;
      nbusy = 0;
      while (busy2 && k < 400) begin
         if (k < 300) begin
            obs_a[k]   = a2;
            obs_b[k]   = b2;
            obs_ctl[k] = {sign2, invb2, inva2, cin2, op2};
         end
         nbusy++;
         @(posedge clk); #1;
         k++;
         start2 = (k == p1) || (k == p2);
      end
      start2 = 1'b0;
      s = sig2;
      d = done2;
      p = pass2;
   endtask

   logic [15:0] s;
   logic        d, p, das;
   int          nb;
   logic [15:0] first_sig;
   logic [31:0] ab;

   initial begin
      rst_n  = 1'b0;
      start1 = 1'b0;
      start2 = 1'b0;
      fault  = 1'b0;

      // start while in reset has no effect
      repeat (2) @(posedge clk);
      #1 start1 = 1'b1; start2 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0; start2 = 1'b0;
      chk("rst_busy", {31'b0, busy2}, 32'd0);
      chk("rst_done", {31'b0, done2}, 32'd0);
      chk("rst_pass", {31'b0, pass2}, 32'd0);
      chk("rst_sig", {16'b0, sig2}, 32'd0);
      chk("rst_alu", {a2 | b2, 9'b0, sign2, invb2, inva2, cin2, op2}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk); #1;
      chk("idle_busy_done", {30'b0, busy2, done2}, 32'd0);

      // single-vector run: ROL ACE1 by 4
      start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      chk("one_busy", {31'b0, busy1}, 32'd1);
      chk("one_a", {16'b0, a1}, 32'h0000ACE1);
      chk("one_b", {16'b0, b1}, 32'h00001234);
      chk("one_ctl", {25'b0, sign1, invb1, inva1, cin1, op1}, 32'd0);
      @(posedge clk); #1;
      chk("one_sig", {16'b0, sig1}, 32'h0000CE1A);
      chk("one_done_busy", {30'b0, done1, busy1}, 32'd2);
      chk("one_pass", {31'b0, pass1}, 32'd1);
      chk("one_alu_idle", {16'b0, a1}, 32'd0);

      // full run with start pulses at 5 and 100 ignored
      run_full(5, 100, s, nb, d, p, das);
      chk("full_busy_cycles", nb, 32'd256);
      chk("full_sig", {16'b0, s}, {16'b0, GOLD});
      chk("full_done_pass", {30'b0, d, p}, 32'd3);
      chk("full_alu_idle", {16'b0, a2}, 32'd0);
      first_sig = s;

      // table of selected vectors vs model
      tbl[0] = '{v: 0, a: 16'hACE1, b: 16'h1234, ctl: 7'd0};
      begin
         int idx [8] = '{1, 7, 8, 16, 37, 64, 127, 255};
         for (int i = 0; i < 8; i++) begin
            ab = model_ab(idx[i]);
            tbl[i+1] = '{v: idx[i], a: ab[31:16], b: ab[15:0], ctl: 7'(idx[i] % 128)};
         end
      end
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("vec%0d", tbl[i].v),
             {obs_a[tbl[i].v], obs_b[tbl[i].v]}, {tbl[i].a, tbl[i].b});
         chk($sformatf("ctl%0d", tbl[i].v), {25'b0, obs_ctl[tbl[i].v]}, {25'b0, tbl[i].ctl});
      end

      // start in DONE: identical signature; random in-run start pulses ignored
      run_full(int'($urandom_range(1, 254)), int'($urandom_range(1, 254)), s, nb, d, p, das);
      chk("rerun_done_cleared", {31'b0, das}, 32'd0);
      chk("rerun_sig", {16'b0, s}, {16'b0, first_sig});
      chk("rerun_cycles", nb, 32'd256);
      chk("rerun_pass", {31'b0, p}, 32'd1);

      // stuck-at-0 on alu_out[0]
      fault = 1'b1;
      run_full(0, 0, s, nb, d, p, das);
      fault = 1'b0;
      chk("fault_sig_differs", {31'b0, s != GOLD}, 32'd1);
      chk("fault_done_pass", {30'b0, d, p}, 32'd2);

      // asynchronous reset at vector 37
      @(posedge clk); #1 start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      repeat (37) @(posedge clk);
      #1;
      ab = model_ab(37);
      chk("v37_a", {16'b0, a2}, {16'b0, ab[31:16]});
      rst_n = 1'b0;
      #1;
      chk("async_busy_done_pass", {29'b0, busy2, done2, pass2}, 32'd0);
      chk("async_sig", {16'b0, sig2}, 32'd0);
      chk("async_alu", {a2 | b2, 9'b0, sign2, invb2, inva2, cin2, op2}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      run_full(0, 0, s, nb, d, p, das);
      chk("post_rst_sig", {16'b0, s}, {16'b0, GOLD});
      chk("post_rst_done_pass", {30'b0, d, p}, 32'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
